csc_column_walker: RTL and testbench
====================================

# csc_column_walker

Sequencer that sits directly downstream of the PE's later address spad and walks a zero-terminated CSC address vector one column at a time. It drives the spad's read index/increment controls, turns consecutive cumulative end pointers into per-column (start, length) descriptors, and hands them over a valid/ready interface to the PE's MAC datapath. It also detects malformed vectors: unwritten entries, non-monotonic pointers and a missing terminator.

## Interface
- SKIP_EMPTY, 0, when 1, zero-length columns are consumed internally and never presented on col_*.
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  pulse; begins a walk (ignored unless idle)
- start_col  in  5  first column to walk, sampled with start
- abort  in  1  return to idle immediately; no done pulse
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse at end of walk (normal or error)
- err_unwritten  out  1  sticky until next start; entry 127 read
- err_order  out  1  sticky; end pointer < previous pointer
- err_overflow  out  1  sticky; column 31 accepted with no terminator
- addr_in  in  7  spad data_out (combinational from spad read pointer)
- spad_read_idx  out  5  spad read_idx
- spad_read_idx_en  out  1  spad read_idx_en
- spad_addr_read_inc  out  1  spad addr_read_inc
- col_valid  out  1  descriptor valid
- col_ready  in  1  datapath accepts descriptor
- col_idx  out  5  column number
- col_start  out  7  first nonzero index of column
- col_len  out  7  nonzero count of column (end − start)

## Operation
- Encoding: entry j = cumulative end pointer of column j; column j spans [entry j−1, entry j); entry −1 ≡ 0; value 0 = terminator; 127 = unwritten (spad reset value).
- States: IDLE, SEEK, LOAD, EMIT, DONE.
- IDLE: on start: clear err_*, col ← start_col. If start_col==0: prev ← 0, spad_read_idx_en=1 with idx 0, → LOAD. Else idx = start_col−1, → SEEK.
- SEEK: addr_in = entry start_col−1. 0 → pulse inc (spad self-rewinds), → DONE. 127 → err_unwritten, → DONE. Else prev ← addr_in, pulse inc, → LOAD.
- LOAD: addr_in = entry col. 0 → pulse inc, → DONE (clean end). 127 → err_unwritten, → DONE. addr_in < prev → err_order, → DONE. Else register col_start=prev, col_len=addr_in−prev, col_idx=col, end ← addr_in. If SKIP_EMPTY and col_len==0: apply the advance rule, stay in LOAD. Otherwise → EMIT.
- Advance rule: prev ← end, pulse inc, col ← col+1. If col was 31: err_overflow, → DONE.
- EMIT: col_valid=1, outputs held stable. On col_ready: apply the advance rule, → LOAD.
- DONE: done=1 for one cycle, → IDLE.
- abort in any state: → IDLE next cycle, col_valid drops, no inc or done issued, err_* retained.
- Arithmetic: 7-bit unsigned; subtraction only after the order check, so col_len never wraps.

## Timing
- Reset: state IDLE; busy, done, err_*, col_valid, spad_* strobes = 0; col_idx, col_start, col_len = 0.
- spad_read_idx_en and spad_addr_read_inc are combinational from state/addr_in, at most one per cycle, and never both in the same cycle.
- addr_in is valid the cycle after an idx_en or inc, matching the registered spad pointer.
- Latency: start → first col_valid = 2 cycles (start_col 0) or 3 cycles (start_col > 0).
- Throughput: one descriptor per 2 cycles (LOAD + EMIT) when col_ready is held high.
- col_valid, once high, stays high with stable data until col_ready; no retraction except on abort or reset.
- start while busy has no effect.

## Structure
- Shared package: ADDR_W=7, IDX_W=5, SPAD_DEPTH=32, ADDR_TERM=7'd0, ADDR_UNWRITTEN=7'd127, state enum.
- Single module; no sub-module. The FSM and the descriptor register are one unit.

## Test plan
- Vector {3,5,5,9,0}, start_col 0, ready high -> descriptors (0,0,3), (1,3,2), (2,5,0), (3,5,4); then done; 4 inc pulses before terminator plus 1 on terminator; spad pointer back at 0.
- Same vector, SKIP_EMPTY=1 -> column 2 never presented; 3 descriptors; done.
- Same vector, start_col 2 -> idx_en with idx 1; first descriptor (2,5,0) at cycle 3.
- Vector {4,2,0} -> descriptor (0,0,4), then err_order, done, no descriptor for column 1.
- Unwritten spad after reset, start -> err_unwritten, done 2 cycles after start, col_valid never high.
- 32 entries 1..32, no terminator, plus backpressure (ready low 3 cycles per column) -> data held stable; err_overflow after column 31. Separately, abort mid-EMIT -> idle, no done.

Source files
------------

// File: rtl/csc_column_walker_pkg.sv
// Shared definitions for the CSC column walker.
// Widths of the spad address/index buses, the reserved entry values, and
// the walker state encoding.
package csc_column_walker_pkg;

    localparam int ADDR_W     = 7;
    localparam int IDX_W      = 5;
    localparam int SPAD_DEPTH = 32;

    localparam logic [ADDR_W-1:0] ADDR_TERM      = 7'd0;
    localparam logic [ADDR_W-1:0] ADDR_UNWRITTEN = 7'd127;
    localparam logic [IDX_W-1:0]  LAST_COL       = IDX_W'(SPAD_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEEK,
        LOAD,
        EMIT,
        DONE
    } state_t;

endpackage

// File: rtl/csc_column_walker.sv
// Walks a zero-terminated CSC address vector held in the later address spad
// and turns consecutive cumulative end pointers into (column, start, length)
// descriptors presented on a valid/ready interface to the MAC datapath.
// Flags unwritten entries, non-monotonic pointers and a missing terminator.
//
// Ports
//   clock, reset            clock, synchronous active-high reset
//   start, start_col        begin a walk at start_col (only when idle)
//   abort                   return to idle next cycle, no done pulse
//   busy, done              walk in progress / one-cycle end-of-walk pulse
//   err_unwritten/order/overflow   sticky error flags, cleared by start
//   addr_in                 spad data_out for the current read pointer
//   spad_read_idx(_en)      load the spad read pointer
//   spad_addr_read_inc      advance the spad read pointer
//   col_valid, col_ready    descriptor handshake
//   col_idx/start/len       descriptor payload
//
// state | meaning
// IDLE  | waiting for start
// SEEK  | reading entry start_col-1 to obtain the first column's start
// LOAD  | reading entry col, building the descriptor
// EMIT  | presenting the descriptor until col_ready
// DONE  | one-cycle done pulse
module csc_column_walker
    import csc_column_walker_pkg::*;
#(
    parameter bit SKIP_EMPTY = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [IDX_W-1:0]  start_col,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err_unwritten,
    output logic              err_order,
    output logic              err_overflow,
    input  logic [ADDR_W-1:0] addr_in,
    output logic [IDX_W-1:0]  spad_read_idx,
    output logic              spad_read_idx_en,
    output logic              spad_addr_read_inc,
    output logic              col_valid,
    input  logic              col_ready,
    output logic [IDX_W-1:0]  col_idx,
    output logic [ADDR_W-1:0] col_start,
    output logic [ADDR_W-1:0] col_len
);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    col_q, col_d;
    logic [ADDR_W-1:0]   prev_q, prev_d;
    logic [ADDR_W-1:0]   end_q, end_d;
    logic [IDX_W-1:0]    col_idx_d;
    logic [ADDR_W-1:0]   col_start_d, col_len_d;
    logic                err_unwritten_d, err_order_d, err_overflow_d;
    logic                advance;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            col_q         <= '0;
            prev_q        <= '0;
            end_q         <= '0;
            col_idx       <= '0;
            col_start     <= '0;
            col_len       <= '0;
            err_unwritten <= 1'b0;
            err_order     <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            prev_q        <= prev_d;
            end_q         <= end_d;
            col_idx       <= col_idx_d;
            col_start     <= col_start_d;
            col_len       <= col_len_d;
            err_unwritten <= err_unwritten_d;
            err_order     <= err_order_d;
            err_overflow  <= err_overflow_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        col_d              = col_q;
        prev_d             = prev_q;
        end_d              = end_q;
        col_idx_d          = col_idx;
        col_start_d        = col_start;
        col_len_d          = col_len;
        err_unwritten_d    = err_unwritten;
        err_order_d        = err_order;
        err_overflow_d     = err_overflow;
        spad_read_idx      = '0;
        spad_read_idx_en   = 1'b0;
        spad_addr_read_inc = 1'b0;
        advance            = 1'b0;

        // Abort freezes everything except the state, so no strobe, no
        // error update and no descriptor change leaks out in that cycle.
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        err_unwritten_d  = 1'b0;
                        err_order_d      = 1'b0;
                        err_overflow_d   = 1'b0;
                        col_d            = start_col;
                        prev_d           = '0;
                        spad_read_idx_en = 1'b1;
                        if (start_col == '0) begin
                            state_d = LOAD;
                        end else begin
                            spad_read_idx = start_col - 1'b1;
                            state_d       = SEEK;
                        end
                    end
                end

                SEEK: begin
                    if (addr_in == ADDR_TERM) begin
                        // Inc on the terminator lets the spad rewind itself.
                        spad_addr_read_inc = 1'b1;
                        state_d            = DONE;
                    end else if (addr_in == ADDR_UNWRITTEN) begin
                        err_unwritten_d = 1'b1;
                        state_d         = DONE;
                    end else begin
                        prev_d             = addr_in;
                        spad_addr_read_inc = 1'b1;
                        state_d            = LOAD;
                    end
                end

                LOAD: begin
                    if (addr_in == ADDR_TERM) begin
                        spad_addr_read_inc = 1'b1;
                        state_d            = DONE;
                    end else if (addr_in == ADDR_UNWRITTEN) begin
                        err_unwritten_d = 1'b1;
                        state_d         = DONE;
                    end else if (addr_in < prev_q) begin
                        err_order_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        // Order already checked, so the length cannot wrap.
                        col_idx_d   = col_q;
                        col_start_d = prev_q;
                        col_len_d   = addr_in - prev_q;
                        end_d       = addr_in;
                        if (SKIP_EMPTY && (addr_in == prev_q)) begin
                            advance = 1'b1;
                            state_d = LOAD;
                        end else begin
                            state_d = EMIT;
                        end
                    end
                end

                EMIT: begin
                    if (col_ready) begin
                        advance = 1'b1;
                        state_d = LOAD;
                    end
                end

                DONE: begin
                    state_d = IDLE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase

            // end_d holds the current column's end in both LOAD (fresh)
            // and EMIT (registered), so one advance path serves both.
            if (advance) begin
                prev_d             = end_d;
                spad_addr_read_inc = 1'b1;
                col_d              = col_q + 1'b1;
                if (col_q == LAST_COL) begin
                    err_overflow_d = 1'b1;
                    state_d        = DONE;
                end
            end
        end
    end

    assign busy      = (state_q == SEEK) || (state_q == LOAD) || (state_q == EMIT);
    assign done      = (state_q == DONE);
    assign col_valid = (state_q == EMIT);

endmodule

// File: tb/tb_csc_column_walker.sv
`timescale 1ns/1ps
module tb_csc_column_walker;
    import csc_column_walker_pkg::*;

    typedef struct packed {
        logic [4:0] idx;
        logic [6:0] st;
        logic [6:0] len;
    } desc_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset, start, start_skip, abort, col_ready;
    logic [4:0] start_col;

    logic       busy, done, err_unwritten, err_order, err_overflow;
    logic       idx_en, inc, col_valid;
    logic [4:0] read_idx, col_idx;
    logic [6:0] addr_in, col_start, col_len;

    logic       s_busy, s_done, s_err_unwritten, s_err_order, s_err_overflow;
    logic       s_idx_en, s_inc, s_col_valid;
    logic [4:0] s_read_idx, s_col_idx;
    logic [6:0] s_addr_in, s_col_start, s_col_len;

    csc_column_walker #(.SKIP_EMPTY(1'b0)) dut (
        .clock(clock), .reset(reset), .start(start), .start_col(start_col), .abort(abort),
        .busy(busy), .done(done), .err_unwritten(err_unwritten), .err_order(err_order),
        .err_overflow(err_overflow), .addr_in(addr_in), .spad_read_idx(read_idx),
        .spad_read_idx_en(idx_en), .spad_addr_read_inc(inc), .col_valid(col_valid),
        .col_ready(col_ready), .col_idx(col_idx), .col_start(col_start), .col_len(col_len)
    );

    csc_column_walker #(.SKIP_EMPTY(1'b1)) dut_skip (
        .clock(clock), .reset(reset), .start(start_skip), .start_col(start_col), .abort(abort),
        .busy(s_busy), .done(s_done), .err_unwritten(s_err_unwritten), .err_order(s_err_order),
        .err_overflow(s_err_overflow), .addr_in(s_addr_in), .spad_read_idx(s_read_idx),
        .spad_read_idx_en(s_idx_en), .spad_addr_read_inc(s_inc), .col_valid(s_col_valid),
        .col_ready(col_ready), .col_idx(s_col_idx), .col_start(s_col_start), .col_len(s_col_len)
    );

    // Spad model: registered read pointer, combinational data_out, self-rewind
    // when incremented while pointing at the terminator.
    logic [6:0] mem [0:31];
    logic [4:0] ptr, s_ptr;
    assign addr_in   = mem[ptr];
    assign s_addr_in = mem[s_ptr];

    always @(posedge clock) begin
        if (reset) begin
            ptr   <= 5'd0;
            s_ptr <= 5'd0;
        end else begin
            if (idx_en)   ptr <= read_idx;
            else if (inc) ptr <= (mem[ptr] == 7'd0) ? 5'd0 : ptr + 5'd1;
            if (s_idx_en)   s_ptr <= s_read_idx;
            else if (s_inc) s_ptr <= (mem[s_ptr] == 7'd0) ? 5'd0 : s_ptr + 5'd1;
        end
    end

    // Event recorder, sampled on the falling edge.
    int    cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0;
    int    inc_cnt = 0, idx_en_cnt = 0, both_cnt = 0, valid_cnt = 0, unstable_cnt = 0;
    logic [4:0] last_idx = 5'd0;
    desc_t obs [0:255];
    int    obs_cyc [0:255];
    int    obs_n = 0;
    desc_t s_obs [0:255];
    int    s_obs_n = 0, s_done_cnt = 0;
    logic  hold = 1'b0;
    desc_t held = '0;

    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (!reset) begin
            if (start) start_cyc <= cyc;
            if (idx_en) begin
                idx_en_cnt <= idx_en_cnt + 1;
                last_idx   <= read_idx;
            end
            if (inc) inc_cnt <= inc_cnt + 1;
            if (idx_en && inc) both_cnt <= both_cnt + 1;
            if (col_valid) valid_cnt <= valid_cnt + 1;
            if (hold && (!col_valid || ({col_idx, col_start, col_len} != held)))
                unstable_cnt <= unstable_cnt + 1;
            hold <= col_valid && !col_ready && !abort;
            held <= {col_idx, col_start, col_len};
            if (col_valid && col_ready && !abort) begin
                obs[obs_n]     <= {col_idx, col_start, col_len};
                obs_cyc[obs_n] <= cyc;
                obs_n          <= obs_n + 1;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (s_col_valid && col_ready && !abort) begin
                s_obs[s_obs_n] <= {s_col_idx, s_col_start, s_col_len};
                s_obs_n        <= s_obs_n + 1;
            end
            if (s_done) s_done_cnt <= s_done_cnt + 1;
        end
    end

    int    pass_cnt = 0, total_cnt = 0;
    int    rd = 0, s_rd = 0;
    desc_t exp_q [$];
    desc_t e;

    function automatic desc_t mk(input logic [4:0] i, input logic [6:0] s, input logic [6:0] l);
        return {i, s, l};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input logic [4:0] c, input bit skip);
        start_col = c;
        if (skip) start_skip = 1'b1; else start = 1'b1;
        tick(1);
        start = 1'b0;
        start_skip = 1'b0;
    endtask

    task automatic wait_done(input bit skip, input int d0, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if ((skip ? s_done_cnt : done_cnt) != d0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        tick(1);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = 7'd127;
    endtask

    task automatic load_basic();
        clear_mem();
        mem[0] = 7'd3; mem[1] = 7'd5; mem[2] = 7'd5; mem[3] = 7'd9; mem[4] = 7'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
        total_cnt++; if (col_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", col_valid); else pass_cnt++;
        total_cnt++; if ({idx_en, inc} !== 2'b00) $display("FAIL reset_strobes: got %b expected 00", {idx_en, inc}); else pass_cnt++;
        total_cnt++;
        if ({err_unwritten, err_order, err_overflow} !== 3'b000)
            $display("FAIL reset_err: got %b expected 000", {err_unwritten, err_order, err_overflow});
        else pass_cnt++;
        total_cnt++;
        if ({col_idx, col_start, col_len} !== 19'd0)
            $display("FAIL reset_desc: got (%0d,%0d,%0d) expected (0,0,0)", col_idx, col_start, col_len);
        else pass_cnt++;
        reset = 1'b0;
        tick(2);
        total_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else pass_cnt++;
    endtask

    task automatic test_basic();
        int i0, e0, b0, d0, rd0;
        bit ok;
        load_basic();
        col_ready = 1'b1;
        exp_q.push_back(mk(5'd0, 7'd0, 7'd3));
        exp_q.push_back(mk(5'd1, 7'd3, 7'd2));
        exp_q.push_back(mk(5'd2, 7'd5, 7'd0));
        exp_q.push_back(mk(5'd3, 7'd5, 7'd4));
        i0 = inc_cnt; e0 = idx_en_cnt; b0 = both_cnt; d0 = done_cnt; rd0 = obs_n; rd = obs_n;
        pulse_start(5'd0, 1'b0);
        total_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b expected 1", busy); else pass_cnt++;
        wait_done(1'b0, d0, 60, ok);
        total_cnt++; if (!ok) $display("FAIL basic_timeout: done not seen, expected within 60 cycles"); else pass_cnt++;
        total_cnt++;
        if (obs_n - rd0 != 4) $display("FAIL basic_count: got %0d descriptors expected 4", obs_n - rd0); else pass_cnt++;
        if (obs_n - rd0 == 4) begin
            total_cnt++;
            if (obs_cyc[rd0] - start_cyc != 2)
                $display("FAIL basic_latency: got %0d expected 2", obs_cyc[rd0] - start_cyc);
            else pass_cnt++;
            total_cnt++;
            if (obs_cyc[rd0+3] - obs_cyc[rd0] != 6)
                $display("FAIL basic_throughput: got %0d cycles for 3 gaps expected 6", obs_cyc[rd0+3] - obs_cyc[rd0]);
            else pass_cnt++;
        end
        while (rd < obs_n) begin
            total_cnt++;
            if (exp_q.size() == 0) $display("FAIL basic_desc: got extra (%0d,%0d,%0d) expected none", obs[rd].idx, obs[rd].st, obs[rd].len);
            else begin
                e = exp_q.pop_front();
                if (obs[rd] !== e) $display("FAIL basic_desc: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", obs[rd].idx, obs[rd].st, obs[rd].len, e.idx, e.st, e.len);
                else pass_cnt++;
            end
            rd++;
        end
        total_cnt++;
        if (exp_q.size() != 0) begin $display("FAIL basic_missing: got %0d unsent expected 0", exp_q.size()); exp_q.delete(); end else pass_cnt++;
        total_cnt++; if (inc_cnt - i0 != 5) $display("FAIL basic_inc: got %0d expected 5", inc_cnt - i0); else pass_cnt++;
        total_cnt++; if (idx_en_cnt - e0 != 1) $display("FAIL basic_idx_en: got %0d expected 1", idx_en_cnt - e0); else pass_cnt++;
        total_cnt++; if (last_idx !== 5'd0) $display("FAIL basic_idx: got %0d expected 0", last_idx); else pass_cnt++;
        total_cnt++; if (both_cnt - b0 != 0) $display("FAIL basic_both_strobes: got %0d expected 0", both_cnt - b0); else pass_cnt++;
        total_cnt++; if (ptr !== 5'd0) $display("FAIL basic_ptr: got %0d expected 0", ptr); else pass_cnt++;
        total_cnt++;
        if ({err_unwritten, err_order, err_overflow} !== 3'b000)
            $display("FAIL basic_err: got %b expected 000", {err_unwritten, err_order, err_overflow});
        else pass_cnt++;
    endtask

    task automatic test_skip_empty();
        int d0;
        bit ok;
        load_basic();
        col_ready = 1'b1;
        exp_q.push_back(mk(5'd0, 7'd0, 7'd3));
        exp_q.push_back(mk(5'd1, 7'd3, 7'd2));
        exp_q.push_back(mk(5'd3, 7'd5, 7'd4));
        d0 = s_done_cnt; s_rd = s_obs_n;
        pulse_start(5'd0, 1'b1);
        wait_done(1'b1, d0, 60, ok);
        total_cnt++; if (!ok) $display("FAIL skip_timeout: done not seen, expected within 60 cycles"); else pass_cnt++;
        while (s_rd < s_obs_n) begin
            total_cnt++;
            if (exp_q.size() == 0) $display("FAIL skip_desc: got extra (%0d,%0d,%0d) expected none", s_obs[s_rd].idx, s_obs[s_rd].st, s_obs[s_rd].len);
            else begin
                e = exp_q.pop_front();
                if (s_obs[s_rd] !== e) $display("FAIL skip_desc: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", s_obs[s_rd].idx, s_obs[s_rd].st, s_obs[s_rd].len, e.idx, e.st, e.len);
                else pass_cnt++;
            end
            s_rd++;
        end
        total_cnt++;
        if (exp_q.size() != 0) begin $display("FAIL skip_missing: got %0d unsent expected 0", exp_q.size()); exp_q.delete(); end else pass_cnt++;
        total_cnt++; if (s_ptr !== 5'd0) $display("FAIL skip_ptr: got %0d expected 0", s_ptr); else pass_cnt++;
    endtask

    task automatic test_start_col();
        int i0, d0, rd0;
        bit ok;
        load_basic();
        col_ready = 1'b1;
        exp_q.push_back(mk(5'd2, 7'd5, 7'd0));
        exp_q.push_back(mk(5'd3, 7'd5, 7'd4));
        i0 = inc_cnt; d0 = done_cnt; rd0 = obs_n; rd = obs_n;
        pulse_start(5'd2, 1'b0);
        wait_done(1'b0, d0, 60, ok);
        total_cnt++; if (!ok) $display("FAIL startcol_timeout: done not seen, expected within 60 cycles"); else pass_cnt++;
        total_cnt++; if (last_idx !== 5'd1) $display("FAIL startcol_idx: got %0d expected 1", last_idx); else pass_cnt++;
        if (obs_n > rd0) begin
            total_cnt++;
            if (obs_cyc[rd0] - start_cyc != 3)
                $display("FAIL startcol_latency: got %0d expected 3", obs_cyc[rd0] - start_cyc);
            else pass_cnt++;
        end
        while (rd < obs_n) begin
            total_cnt++;
            if (exp_q.size() == 0) $display("FAIL startcol_desc: got extra (%0d,%0d,%0d) expected none", obs[rd].idx, obs[rd].st, obs[rd].len);
            else begin
                e = exp_q.pop_front();
                if (obs[rd] !== e) $display("FAIL startcol_desc: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", obs[rd].idx, obs[rd].st, obs[rd].len, e.idx, e.st, e.len);
                else pass_cnt++;
            end
            rd++;
        end
        total_cnt++;
        if (exp_q.size() != 0) begin $display("FAIL startcol_missing: got %0d unsent expected 0", exp_q.size()); exp_q.delete(); end else pass_cnt++;
        total_cnt++; if (inc_cnt - i0 != 4) $display("FAIL startcol_inc: got %0d expected 4", inc_cnt - i0); else pass_cnt++;
    endtask

    task automatic test_order();
        int i0, d0;
        bit ok;
        clear_mem();
        mem[0] = 7'd4; mem[1] = 7'd2; mem[2] = 7'd0;
        col_ready = 1'b1;
        exp_q.push_back(mk(5'd0, 7'd0, 7'd4));
        i0 = inc_cnt; d0 = done_cnt; rd = obs_n;
        pulse_start(5'd0, 1'b0);
        wait_done(1'b0, d0, 60, ok);
        total_cnt++; if (!ok) $display("FAIL order_timeout: done not seen, expected within 60 cycles"); else pass_cnt++;
        while (rd < obs_n) begin
            total_cnt++;
            if (exp_q.size() == 0) $display("FAIL order_desc: got extra (%0d,%0d,%0d) expected none", obs[rd].idx, obs[rd].st, obs[rd].len);
            else begin
                e = exp_q.pop_front();
                if (obs[rd] !== e) $display("FAIL order_desc: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", obs[rd].idx, obs[rd].st, obs[rd].len, e.idx, e.st, e.len);
                else pass_cnt++;
            end
            rd++;
        end
        total_cnt++;
        if (exp_q.size() != 0) begin $display("FAIL order_missing: got %0d unsent expected 0", exp_q.size()); exp_q.delete(); end else pass_cnt++;
        total_cnt++;
        if ({err_unwritten, err_order, err_overflow} !== 3'b010)
            $display("FAIL order_err: got %b expected 010", {err_unwritten, err_order, err_overflow});
        else pass_cnt++;
        total_cnt++; if (inc_cnt - i0 != 1) $display("FAIL order_inc: got %0d expected 1", inc_cnt - i0); else pass_cnt++;
    endtask

    task automatic test_unwritten();
        int v0, d0;
        bit ok;
        clear_mem();
        col_ready = 1'b1;
        v0 = valid_cnt; d0 = done_cnt; rd = obs_n;
        pulse_start(5'd0, 1'b0);
        wait_done(1'b0, d0, 20, ok);
        total_cnt++; if (!ok) $display("FAIL unwr_timeout: done not seen, expected within 20 cycles"); else pass_cnt++;
        total_cnt++; if (done_cyc - start_cyc != 2) $display("FAIL unwr_done_latency: got %0d expected 2", done_cyc - start_cyc); else pass_cnt++;
        total_cnt++;
        if ({err_unwritten, err_order, err_overflow} !== 3'b100)
            $display("FAIL unwr_err: got %b expected 100", {err_unwritten, err_order, err_overflow});
        else pass_cnt++;
        total_cnt++; if (valid_cnt - v0 != 0) $display("FAIL unwr_valid: got %0d valid cycles expected 0", valid_cnt - v0); else pass_cnt++;
    endtask

    task automatic test_overflow_backpressure();
        int d0, u0, k;
        bit ok;
        for (int i = 0; i < 32; i++) mem[i] = 7'(i + 1);
        for (int j = 0; j < 32; j++) exp_q.push_back(mk(5'(j), 7'(j), 7'd1));
        d0 = done_cnt; u0 = unstable_cnt; rd = obs_n;
        col_ready = 1'b0;
        pulse_start(5'd0, 1'b0);
        ok = 1'b0;
        for (k = 0; k < 800; k++) begin
            col_ready = ((k % 4) == 3);
            tick(1);
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
        col_ready = 1'b1;
        tick(1);
        total_cnt++; if (!ok) $display("FAIL ovf_timeout: done not seen, expected within 800 cycles"); else pass_cnt++;
        while (rd < obs_n) begin
            total_cnt++;
            if (exp_q.size() == 0) $display("FAIL ovf_desc: got extra (%0d,%0d,%0d) expected none", obs[rd].idx, obs[rd].st, obs[rd].len);
            else begin
                e = exp_q.pop_front();
                if (obs[rd] !== e) $display("FAIL ovf_desc: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", obs[rd].idx, obs[rd].st, obs[rd].len, e.idx, e.st, e.len);
                else pass_cnt++;
            end
            rd++;
        end
        total_cnt++;
        if (exp_q.size() != 0) begin $display("FAIL ovf_missing: got %0d unsent expected 0", exp_q.size()); exp_q.delete(); end else pass_cnt++;
        total_cnt++; if (unstable_cnt - u0 != 0) $display("FAIL ovf_stable: got %0d changes while stalled expected 0", unstable_cnt - u0); else pass_cnt++;
        total_cnt++;
        if ({err_unwritten, err_order, err_overflow} !== 3'b001)
            $display("FAIL ovf_err: got %b expected 001", {err_unwritten, err_order, err_overflow});
        else pass_cnt++;
    endtask

    task automatic test_abort();
        int i0, d0;
        bit ok;
        load_basic();
        col_ready = 1'b0;
        pulse_start(5'd0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (col_valid) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        total_cnt++; if (!ok) $display("FAIL abort_reach_emit: col_valid not seen, expected within 10 cycles"); else pass_cnt++;
        // start while busy must be ignored
        pulse_start(5'd3, 1'b0);
        tick(1);
        total_cnt++;
        if ({col_valid, col_idx, col_start, col_len} !== {1'b1, mk(5'd0, 7'd0, 7'd3)})
            $display("FAIL busy_start: got v%b (%0d,%0d,%0d) expected v1 (0,0,3)", col_valid, col_idx, col_start, col_len);
        else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL busy_flag: got %b expected 1", busy); else pass_cnt++;
        i0 = inc_cnt; d0 = done_cnt;
        abort = 1'b1;
        col_ready = 1'b1;
        tick(1);
        abort = 1'b0;
        col_ready = 1'b0;
        total_cnt++; if (col_valid !== 1'b0) $display("FAIL abort_valid: got %b expected 0", col_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else pass_cnt++;
        tick(4);
        total_cnt++; if (inc_cnt - i0 != 0) $display("FAIL abort_inc: got %0d expected 0", inc_cnt - i0); else pass_cnt++;
        total_cnt++; if (done_cnt - d0 != 0) $display("FAIL abort_done: got %0d expected 0", done_cnt - d0); else pass_cnt++;
        // walker must accept a fresh start afterwards
        col_ready = 1'b1;
        exp_q.push_back(mk(5'd3, 7'd5, 7'd4));
        rd = obs_n; d0 = done_cnt;
        pulse_start(5'd3, 1'b0);
        wait_done(1'b0, d0, 60, ok);
        total_cnt++; if (!ok) $display("FAIL restart_timeout: done not seen, expected within 60 cycles"); else pass_cnt++;
        while (rd < obs_n) begin
            total_cnt++;
            if (exp_q.size() == 0) $display("FAIL restart_desc: got extra (%0d,%0d,%0d) expected none", obs[rd].idx, obs[rd].st, obs[rd].len);
            else begin
                e = exp_q.pop_front();
                if (obs[rd] !== e) $display("FAIL restart_desc: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", obs[rd].idx, obs[rd].st, obs[rd].len, e.idx, e.st, e.len);
                else pass_cnt++;
            end
            rd++;
        end
        total_cnt++;
        if (exp_q.size() != 0) begin $display("FAIL restart_missing: got %0d unsent expected 0", exp_q.size()); exp_q.delete(); end else pass_cnt++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; start_skip = 1'b0; abort = 1'b0;
        col_ready = 1'b0; start_col = 5'd0;
        clear_mem();
        test_reset();
        test_basic();
        test_skip_empty();
        test_start_col();
        test_order();
        test_unwritten();
        test_overflow_backpressure();
        test_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
